// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the clock/timer controller: register map, CTRL bit
// positions and the interval-timer state encoding.
package clock_ctrl_pkg;

  localparam logic [1:0] ADDR_CPU_HALF = 2'd0;
  localparam logic [1:0] ADDR_TICK_DIV = 2'd1;
  localparam logic [1:0] ADDR_RELOAD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int CTRL_TEN  = 0;
  localparam int CTRL_IEN  = 1;
  localparam int CTRL_PEND = 2;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUNNING = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/clock_ctrl_if.sv
// CPU-side register port of the clock/timer controller, plus interrupt acknowledge.
interface clock_ctrl_if;
  logic        REG_WE;
  logic [1:0]  REG_ADDR;
  logic [15:0] REG_WDATA;
  logic [15:0] REG_RDATA;
  logic        IACK;

  modport master (output REG_WE, REG_ADDR, REG_WDATA, IACK, input REG_RDATA);
  modport slave  (input REG_WE, REG_ADDR, REG_WDATA, IACK, output REG_RDATA);
endinterface

// File: rtl/clock_ctrl_prescaler.sv
// Reloadable down-counter: strobes while at zero and reloads with whatever
// reload value is presented on that cycle, so divisor changes never truncate a period.
module clk_prescaler #(
  parameter int             W       = 6,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] reload_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= RST_VAL;
    else if (cnt == '0)
      cnt <= reload_val;
    else
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clock_ctrl.sv
// Programmable CPU clock divider, tick prescaler and reloadable interval timer
// with interrupt request, configured through a 4-register bus port.
module clock_ctrl #(
  parameter logic [5:0]  CPU_HALF_DEFAULT = 6'd1,
  parameter logic [5:0]  TICK_DIV_DEFAULT = 6'd39,
  parameter logic [15:0] RELOAD_DEFAULT   = 16'd999
) (
  input  logic         MCLK_IN,
  input  logic         RESET,
  clock_ctrl_if.slave  bus,
  output logic         CPUCLK,
  output logic         TIMER_TICK,
  output logic         IRQ
);
  import clock_ctrl_pkg::*;

  logic [5:0]  cpu_half_stg, cpu_half_act, tick_div;
  logic [15:0] reload, count, rdata, rd_mux;
  logic        ten, ien, pend, irq_q;
  logic        cpu_zero, tick;
  logic        wr_cpu, wr_tick, wr_reload, wr_ctrl;
  logic        load_cnt, run_tick, expire, pend_clr, pend_d, ien_d;
  tmr_state_e  state, state_nxt;

  assign wr_cpu    = bus.REG_WE && (bus.REG_ADDR == ADDR_CPU_HALF);
  assign wr_tick   = bus.REG_WE && (bus.REG_ADDR == ADDR_TICK_DIV);
  assign wr_reload = bus.REG_WE && (bus.REG_ADDR == ADDR_RELOAD);
  assign wr_ctrl   = bus.REG_WE && (bus.REG_ADDR == ADDR_CTRL);

  clk_prescaler #(.W(6), .RST_VAL(TICK_DIV_DEFAULT)) u_tick (
    .clk(MCLK_IN), .rst(RESET), .reload_val(tick_div), .zero(tick)
  );

  clk_prescaler #(.W(6), .RST_VAL(CPU_HALF_DEFAULT)) u_cpu (
    .clk(MCLK_IN), .rst(RESET), .reload_val(cpu_half_act), .zero(cpu_zero)
  );

  assign TIMER_TICK = tick;

  // The active half only changes on a falling toggle; the low half that follows
  // was already reloaded with the old value, so each full period stays symmetric.
  always_ff @(posedge MCLK_IN) begin
    if (RESET) begin
      CPUCLK       <= 1'b0;
      cpu_half_stg <= CPU_HALF_DEFAULT;
      cpu_half_act <= CPU_HALF_DEFAULT;
      tick_div     <= TICK_DIV_DEFAULT;
      reload       <= RELOAD_DEFAULT;
      ten          <= 1'b0;
      ien          <= 1'b0;
    end else begin
      if (cpu_zero) CPUCLK <= ~CPUCLK;
      if (cpu_zero && CPUCLK) cpu_half_act <= cpu_half_stg;
      if (wr_cpu) cpu_half_stg <= bus.REG_WDATA[5:0];
      if (wr_tick) tick_div <= bus.REG_WDATA[5:0];
      if (wr_reload) reload <= bus.REG_WDATA;
      if (wr_ctrl) ten <= bus.REG_WDATA[CTRL_TEN];
      ien <= ien_d;
    end
  end

  always_ff @(posedge MCLK_IN) begin
    if (RESET) state <= ST_STOPPED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOPPED: if (wr_ctrl && bus.REG_WDATA[CTRL_TEN]) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_RUNNING;
      ST_RUNNING: state_nxt = ST_RUNNING;
      default:    state_nxt = ST_STOPPED;
    endcase
    if (wr_ctrl && !bus.REG_WDATA[CTRL_TEN]) state_nxt = ST_STOPPED;
  end

  always_comb begin
    load_cnt = (state == ST_LOAD);
    run_tick = (state == ST_RUNNING) && tick;
    expire   = run_tick && (count == '0);
  end

  always_ff @(posedge MCLK_IN) begin
    if (RESET)
      count <= '0;
    else if (load_cnt)
      count <= reload;
    else if (run_tick)
      count <= expire ? reload : count - 1'b1;
  end

  // Expiry dominates a simultaneous clear so no interrupt is ever lost.
  always_comb begin
    pend_clr = bus.IACK || (wr_ctrl && bus.REG_WDATA[CTRL_PEND]);
    pend_d   = expire || (pend && !pend_clr);
    ien_d    = wr_ctrl ? bus.REG_WDATA[CTRL_IEN] : ien;
  end

  always_ff @(posedge MCLK_IN) begin
    if (RESET) begin
      pend  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      pend  <= pend_d;
      irq_q <= pend_d && ien_d;
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    rd_mux = '0;
    case (bus.REG_ADDR)
      ADDR_CPU_HALF: rd_mux = {10'd0, cpu_half_stg};
      ADDR_TICK_DIV: rd_mux = {10'd0, tick_div};
      ADDR_RELOAD:   rd_mux = reload;
      ADDR_CTRL:     rd_mux = {13'd0, pend, ien, ten};
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge MCLK_IN) begin
    if (RESET) rdata <= '0;
    else       rdata <= rd_mux;
  end

  assign bus.REG_RDATA = rdata;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is observed.
module tb_clock_ctrl;

  logic MCLK_IN = 1'b0;
  logic RESET;
  logic CPUCLK, TIMER_TICK, IRQ;

  clock_ctrl_if bus();

  clock_ctrl dut (
    .MCLK_IN   (MCLK_IN),
    .RESET     (RESET),
    .bus       (bus.slave),
    .CPUCLK    (CPUCLK),
    .TIMER_TICK(TIMER_TICK),
    .IRQ       (IRQ)
  );

  always #5 MCLK_IN = ~MCLK_IN;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input int n);
    repeat (n) @(posedge MCLK_IN);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_obs(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0d expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] exp, input logic [15:0] obs);
    expect_val(tag, exp);
    check_obs(obs);
  endtask

  task automatic do_reset();
    bus.REG_WE = 1'b0; bus.REG_ADDR = 2'd0; bus.REG_WDATA = 16'd0; bus.IACK = 1'b0;
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.REG_WE = 1'b1; bus.REG_ADDR = a; bus.REG_WDATA = d;
    step(1);
    bus.REG_WE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    bus.REG_ADDR = a;
    expect_val(tag, exp);
    step(1);
    check_obs(bus.REG_RDATA);
  endtask

  task automatic wait_toggle(output int n);
    logic prev;
    prev = CPUCLK;
    n = 0;
    do begin step(1); n++; end while (CPUCLK === prev && n < 300);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin step(1); n++; end while (TIMER_TICK !== 1'b1 && n < 300);
  endtask

  task automatic half(input string tag, input int exp);
    int n;
    expect_val(tag, 16'(exp));
    wait_toggle(n);
    check_obs(16'(n));
  endtask

  task automatic tick_gap(input string tag, input int exp);
    int n;
    expect_val(tag, 16'(exp));
    wait_tick(n);
    check_obs(16'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset state and default CPU clock (half period 2 MCLK)
    do_reset();
    chk("rst_cpuclk", 16'd0, {15'd0, CPUCLK});
    chk("rst_tick",   16'd0, {15'd0, TIMER_TICK});
    chk("rst_irq",    16'd0, {15'd0, IRQ});
    chk("rst_rdata",  16'd0, bus.REG_RDATA);
    for (int i = 0; i < 4; i++) half("dflt_half", 2);

    // Tick period 40, width 1; TICK_DIV change deferred to next reload
    do_reset();
    tick_gap("tick_first", 39);
    step(1);
    chk("tick_width", 16'd0, {15'd0, TIMER_TICK});
    tick_gap("tick_period", 39);
    step(1);
    wr(1, 16'd9);
    tick_gap("tick_no_trunc", 38);
    step(1);
    tick_gap("tick_new_div", 9);

    // Glitch-free CPU_HALF change written mid high half
    do_reset();
    half("pre_high", 2);
    chk("mid_high", 16'd1, {15'd0, CPUCLK});
    wr(0, 16'd4);
    half("old_high_rest", 1);
    half("old_low", 2);
    for (int i = 0; i < 3; i++) half("new_half5", 5);
    wr(0, 16'd0);
    half("low5_rest", 4);
    half("high5_last", 5);
    half("low5_last", 5);
    half("div2_high", 1);
    half("div2_low", 1);

    // RELOAD=2: IRQ on 3rd tick, IACK clears, re-arms
    do_reset();
    wr(2, 16'd2);
    wr(3, 16'd3);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      step(1);
      chk("irq_after_tick", (k == 3) ? 16'd1 : 16'd0, {15'd0, IRQ});
    end
    rd("ctrl_pend", 2'd3, 16'd7);
    bus.IACK = 1'b1;
    step(1);
    bus.IACK = 1'b0;
    chk("iack_clear", 16'd0, {15'd0, IRQ});
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      step(1);
      chk("irq_rearm", (k == 3) ? 16'd1 : 16'd0, {15'd0, IRQ});
    end

    // RELOAD=0: IACK in the expiry cycle loses to the set
    do_reset();
    wr(2, 16'd0);
    wr(3, 16'd3);
    wait_tick(n);
    chk("pre_expiry_irq", 16'd0, {15'd0, IRQ});
    bus.IACK = 1'b1;
    step(1);
    bus.IACK = 1'b0;
    chk("set_wins_irq", 16'd1, {15'd0, IRQ});
    rd("set_wins_pend", 2'd3, 16'd7);
    bus.IACK = 1'b1;
    step(1);
    bus.IACK = 1'b0;
    chk("iack_plain", 16'd0, {15'd0, IRQ});

    // Stop at count=5, restart goes through LOAD; IEN=0 masks IRQ
    do_reset();
    wr(2, 16'd7);
    wr(3, 16'd1);
    for (int k = 0; k < 2; k++) begin wait_tick(n); step(1); end
    wr(3, 16'd0);
    wr(3, 16'd1);
    for (int k = 0; k < 7; k++) begin wait_tick(n); step(1); end
    rd("no_pend_7ticks", 2'd3, 16'd1);
    wait_tick(n);
    step(1);
    rd("pend_8th_tick", 2'd3, 16'd5);
    chk("irq_masked", 16'd0, {15'd0, IRQ});
    wr(3, 16'd0);
    rd("pend_ten0", 2'd3, 16'd4);
    chk("irq_masked2", 16'd0, {15'd0, IRQ});

    // Reset mid-run with PEND=1, IRQ=1 and CPUCLK=1
    wr(2, 16'd123);
    wr(0, 16'd9);
    wr(3, 16'd2);
    chk("irq_unmasked", 16'd1, {15'd0, IRQ});
    n = 0;
    while (CPUCLK !== 1'b1 && n < 300) begin step(1); n++; end
    chk("pre_rst_cpuclk", 16'd1, {15'd0, CPUCLK});
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    chk("midrst_irq",    16'd0, {15'd0, IRQ});
    chk("midrst_cpuclk", 16'd0, {15'd0, CPUCLK});
    chk("midrst_rdata",  16'd0, bus.REG_RDATA);
    rd("midrst_reload",  2'd2, 16'd999);
    rd("midrst_tickdiv", 2'd1, 16'd39);
    rd("midrst_cpuhalf", 2'd0, 16'd1);
    rd("midrst_ctrl",    2'd3, 16'd0);
    half("midrst_half", 2);
    half("midrst_half", 2);

    chk("sb_drained", 16'd0, 16'(sb.size()));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Programmable clock/timer controller for the 68000 board, clocked by the 40 MHz master clock.
- Generates the divided CPU clock and a 1 MHz-default timer tick.
- Runs a reloadable interval timer on that tick and raises a CPU interrupt request.
- The CPU configures it through a small 4-register bus port, so divisors are runtime-programmable instead of fixed.

Parameters:
- CPU_HALF_DEFAULT, 6'd1: CPUCLK half-period minus 1, in MCLK cycles (1 -> 10 MHz).
- TICK_DIV_DEFAULT, 6'd39: tick period minus 1, in MCLK cycles (39 -> 1 MHz).
- RELOAD_DEFAULT, 16'd999: interval timer reload, in ticks.

Ports:
- MCLK_IN  in  1  40 MHz master clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- REG_WE  in  1  register write strobe, one cycle.
- REG_ADDR  in  2  register select.
- REG_WDATA  in  16  write data.
- REG_RDATA  out  16  read data, registered.
- IACK  in  1  interrupt acknowledge pulse.
- CPUCLK  out  1  divided CPU clock.
- TIMER_TICK  out  1  one-MCLK-cycle tick strobe.
- IRQ  out  1  interrupt request, level.

Behaviour:
- One clock (MCLK_IN); reset is synchronous and active-high (RESET).
- Reset values: CPUCLK=0, TIMER_TICK=0, IRQ=0, REG_RDATA=0. Staged and active divisors take their defaults. Timer is STOPPED with count=0; enables and pending are 0. Reset mid-operation aborts everything the same way.
- Register map:
  - 0 = CPU_HALF[5:0].
  - 1 = TICK_DIV[5:0].
  - 2 = RELOAD[15:0].
  - 3 = CTRL: bit0 TEN, bit1 IEN, bit2 PEND. PEND is read-only; writing 1 to bit2 clears it.
  - Unused bits read 0.
- REG_RDATA = register[REG_ADDR], registered, 1-cycle latency, updated every cycle.
- CPU clock:
  - 6-bit down-counter; when it is 0, CPUCLK toggles and the counter reloads with the active half value.
  - A CPU_HALF write goes to a staged register. Active is updated from staged only at a 1->0 toggle, so every emitted period has equal halves (glitch-free divisor change).
  - CPU_HALF=0 gives CPUCLK = MCLK/2.
- Tick prescaler:
  - Free-running 6-bit down-counter.
  - At 0: TIMER_TICK=1 for exactly one cycle, and the counter reloads with TICK_DIV.
  - A TICK_DIV write takes effect at the next reload; the current period is not truncated.
- Interval timer FSM (STOPPED, LOAD, RUNNING):
  - STOPPED: count held. A CTRL write with TEN=1 goes to LOAD.
  - LOAD: count<=RELOAD, then RUNNING next cycle. Ticks during LOAD are ignored.
  - RUNNING, on TIMER_TICK: if count==0, set PEND and count<=RELOAD; else count<=count-1. Period is RELOAD+1 ticks; RELOAD=0 expires every tick.
  - In any state, a CTRL write with TEN=0 goes to STOPPED next cycle, count retained. A later TEN=1 write passes through LOAD again.
  - A RELOAD write while RUNNING does not disturb count; it is used at the next expiry.
- PEND / IRQ:
  - IRQ = PEND & IEN, registered from state (no combinational path from the bus).
  - PEND is cleared by IACK or by a CTRL write with bit2=1.
  - Expiry in the same cycle as a clear: set wins, and PEND stays 1.
  - IEN=0 masks IRQ but PEND still latches.
- Width rules: all counters unsigned, no saturation; wrap is prevented because 0 triggers reload.

Decomposition:
- Package clock_ctrl_pkg holds:
  - register address constants ADDR_CPU_HALF=0, ADDR_TICK_DIV=1, ADDR_RELOAD=2, ADDR_CTRL=3;
  - CTRL bit indices;
  - the FSM state encoding.
- One sub-module, clk_prescaler: a reloadable down-counter emitting a zero strobe with deferred reload value. It is instantiated for the tick path. The CPU path reuses it, with the toggle and half-value staging in the parent.

Test Plan:
- Reset, no writes -> CPUCLK toggles every 2 MCLK cycles (period 4). TIMER_TICK pulses once every 40 cycles, width 1. IRQ=0, REG_RDATA=0 on the cycle after reset.
- Write CPU_HALF=4 while CPUCLK=1 mid-half -> the current high half and following low half keep the old length. The first high half after the next 1->0 toggle is 5 cycles; never an unequal period.
- RELOAD=2, IEN=1, TEN=1 -> PEND and IRQ assert on the 3rd tick after LOAD. IACK clears IRQ next cycle; it reasserts 3 ticks later.
- RELOAD=0, TEN=1; IACK driven in the exact cycle of a tick expiry -> PEND remains 1 (set wins).
- TEN=0 while count=5, then TEN=1 -> count restarts from RELOAD via LOAD. IRQ masked with IEN=0 while PEND reads 1 at addr 3 (REG_RDATA=16'h0004 with TEN=0, IEN=0).
- Assert RESET mid-run with PEND=1 and CPUCLK=1 -> next cycle IRQ=0, CPUCLK=0, state STOPPED, registers back to defaults (addr 2 reads 999).
